// File: rtl/csa_pkg.sv
// Shared op encoding and helpers for the pipelined carry-select accumulator.
package csa_pkg;

   typedef enum logic [1:0] {
      OP_ADD = 2'd0,
      OP_SUB = 2'd1,
      OP_ACC = 2'd2,
      OP_CLR = 2'd3
   } op_e;

   // Ops whose result writes the accumulator
   function automatic logic is_acc_op(op_e o);
      return (o == OP_ACC) || (o == OP_CLR);
   endfunction

endpackage

// File: rtl/csa_dual_block.sv
// BLOCK-bit adder slice producing sum/carry for both possible carry-in values.
module csa_dual_block #(
   parameter int BLOCK = 4
) (
   input  logic [BLOCK-1:0] x,
   input  logic [BLOCK-1:0] y,
   output logic [BLOCK-1:0] sum0,
   output logic [BLOCK-1:0] sum1,
   output logic             carry0,
   output logic             carry1
);

   assign {carry0, sum0} = {1'b0, x} + {1'b0, y};
   assign {carry1, sum1} = {1'b0, x} + {1'b0, y} + {{BLOCK{1'b0}}, 1'b1};

endmodule

// File: rtl/pipe_csa_acc.sv
// Two-stage carry-select adder/accumulator: stage 1 precomputes both block
// outcomes, stage 2 resolves the block carry chain and registers the result.
module pipe_csa_acc
   import csa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int BLOCK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  op_e              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             c_out,
   output logic             ovf,
   output logic [WIDTH-1:0] acc
);

   localparam int NB = WIDTH / BLOCK;

   logic [WIDTH-1:0] opx, opy;
   logic             op_cin;
   logic             s2_adv, s1_adv, acc_busy, accept;

   logic [NB-1:0][BLOCK-1:0] bsum0, bsum1;
   logic [NB-1:0]            bc0, bc1;

   logic                     s1_valid_reg;
   op_e                      s1_op_reg;
   logic                     s1_msb_xy_reg;
   logic [BLOCK-1:0]         s1_blk0_sum_reg;
   logic                     s1_blk0_c_reg;
   logic [NB-1:1][BLOCK-1:0] s1_sum0_reg, s1_sum1_reg;
   logic [NB-1:1]            s1_c0_reg, s1_c1_reg;

   logic [WIDTH-1:0] s_next;
   logic [NB-1:0]    carry;
   logic             ovf_next;

   logic             out_valid_reg, c_out_reg, ovf_reg, out_acc_reg;
   logic [WIDTH-1:0] s_reg, acc_reg;

   // Operand mapping: SUB is a + ~b + 1, ACC adds a onto the accumulator
   always_comb begin
      opx    = a;
      opy    = b;
      op_cin = c_in;
      case (op)
         OP_SUB: begin
            opy    = ~b;
            op_cin = 1'b1;
         end
         OP_ACC: begin
            opx    = acc_reg;
            opy    = a;
            op_cin = 1'b0;
         end
         OP_CLR: begin
            opx    = '0;
            opy    = '0;
            op_cin = 1'b0;
         end
         default: ;
      endcase
   end

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_blk
         csa_dual_block #(.BLOCK(BLOCK)) u_blk (
            .x      (opx[gi*BLOCK +: BLOCK]),
            .y      (opy[gi*BLOCK +: BLOCK]),
            .sum0   (bsum0[gi]),
            .sum1   (bsum1[gi]),
            .carry0 (bc0[gi]),
            .carry1 (bc1[gi])
         );
      end
   endgenerate

   assign s2_adv   = !out_valid_reg || out_ready;
   assign s1_adv   = !s1_valid_reg || s2_adv;
   // acc is read at stage-1 capture, so hold off new requests until it settles
   assign acc_busy = (s1_valid_reg && is_acc_op(s1_op_reg)) || (out_valid_reg && out_acc_reg);
   assign in_ready = s1_adv && !acc_busy;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_reg    <= 1'b0;
         s1_op_reg       <= OP_ADD;
         s1_msb_xy_reg   <= 1'b0;
         s1_blk0_sum_reg <= '0;
         s1_blk0_c_reg   <= 1'b0;
         s1_sum0_reg     <= '0;
         s1_sum1_reg     <= '0;
         s1_c0_reg       <= '0;
         s1_c1_reg       <= '0;
      end else if (s1_adv) begin
         s1_valid_reg <= accept;
         if (accept) begin
            s1_op_reg       <= op;
            s1_msb_xy_reg   <= opx[WIDTH-1] ^ opy[WIDTH-1];
            s1_blk0_sum_reg <= op_cin ? bsum1[0] : bsum0[0];
            s1_blk0_c_reg   <= op_cin ? bc1[0] : bc0[0];
            for (int i = 1; i < NB; i++) begin
               s1_sum0_reg[i] <= bsum0[i];
               s1_sum1_reg[i] <= bsum1[i];
               s1_c0_reg[i]   <= bc0[i];
               s1_c1_reg[i]   <= bc1[i];
            end
         end
      end
   end

   always_comb begin
      s_next            = '0;
      carry             = '0;
      s_next[BLOCK-1:0] = s1_blk0_sum_reg;
      carry[0]          = s1_blk0_c_reg;
      for (int i = 1; i < NB; i++) begin
         s_next[i*BLOCK +: BLOCK] = carry[i-1] ? s1_sum1_reg[i] : s1_sum0_reg[i];
         carry[i]                 = carry[i-1] ? s1_c1_reg[i] : s1_c0_reg[i];
      end
   end

   // Carry into the MSB recovered from the sum bit and the operand MSBs
   assign ovf_next = (s_next[WIDTH-1] ^ s1_msb_xy_reg) ^ carry[NB-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         s_reg         <= '0;
         c_out_reg     <= 1'b0;
         ovf_reg       <= 1'b0;
         out_acc_reg   <= 1'b0;
         acc_reg       <= '0;
      end else if (s2_adv) begin
         out_valid_reg <= s1_valid_reg;
         if (s1_valid_reg) begin
            s_reg       <= s_next;
            c_out_reg   <= carry[NB-1];
            ovf_reg     <= ovf_next;
            out_acc_reg <= is_acc_op(s1_op_reg);
            if (is_acc_op(s1_op_reg))
               acc_reg <= s_next;
         end
      end
   end

   assign out_valid = out_valid_reg;
   assign s         = s_reg;
   assign c_out     = c_out_reg;
   assign ovf       = ovf_reg;
   assign acc       = acc_reg;

endmodule

// File: tb/tb_pipe_csa_acc.sv
// Directed and randomized checks for pipe_csa_acc at 32, 16 and 64 bit widths.
module tb_pipe_csa_acc;
   import csa_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total  = 0;
   int passed = 0;

   logic        rst, in_valid, c_in, out_ready;
   op_e         op;
   logic [31:0] a, b;
   logic        in_ready, out_valid, c_out, ovf;
   logic [31:0] s, acc;

   logic        sw_valid, sw_cin;
   op_e         sw_op;
   logic [15:0] a16, b16, s16, acc16;
   logic        rdy16, ov16, c16, ovf16;
   logic [63:0] a64, b64, s64, acc64;
   logic        rdy64, ov64, c64, ovf64;

   pipe_csa_acc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
      .s(s), .c_out(c_out), .ovf(ovf), .acc(acc)
   );

   pipe_csa_acc #(.WIDTH(16), .BLOCK(4)) dut16 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy16), .op(sw_op),
      .a(a16), .b(b16), .c_in(sw_cin), .out_valid(ov16), .out_ready(out_ready),
      .s(s16), .c_out(c16), .ovf(ovf16), .acc(acc16)
   );

   pipe_csa_acc #(.WIDTH(64), .BLOCK(8)) dut64 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy64), .op(sw_op),
      .a(a64), .b(b64), .c_in(sw_cin), .out_valid(ov64), .out_ready(out_ready),
      .s(s64), .c_out(c64), .ovf(ovf64), .acc(acc64)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; op = OP_ADD;
      a = '0; b = '0; c_in = 1'b0;
      sw_valid = 1'b0; sw_op = OP_ADD; sw_cin = 1'b0;
      a16 = '0; b16 = '0; a64 = '0; b64 = '0;
      #1;
      total++;
      if ({out_valid, s, c_out, ovf, acc} !== {1'b0, 32'h0, 1'b0, 1'b0, 32'h0})
         $display("FAIL reset_state: got ov=%b s=%h c=%b ovf=%b acc=%h, want all zero",
                  out_valid, s, c_out, ovf, acc);
      else passed++;
      step(); step();
      rst = 1'b0;
      #1;
      total++;
      if ({in_ready, out_valid} !== 2'b10)
         $display("FAIL reset_release: got in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
      else passed++;
      $display("reset released");
   endtask

   // One request, checks 2-cycle latency, result, acc and the ACC/CLR interlock
   task automatic send_check(input op_e o, input logic [31:0] va, input logic [31:0] vb,
                             input logic ci, input logic [31:0] es, input logic ec,
                             input logic eo, input logic [31:0] eacc, input string nm);
      logic exp_rdy;
      exp_rdy = !is_acc_op(o);
      in_valid = 1'b1; op = o; a = va; b = vb; c_in = ci;
      #1;
      total++;
      if (in_ready !== 1'b1)
         $display("FAIL %s_ready: got in_ready=%b, want 1", nm, in_ready);
      else passed++;
      @(posedge clk); #1;
      in_valid = 1'b0;
      total++;
      if ({out_valid, in_ready} !== {1'b0, exp_rdy})
         $display("FAIL %s_stage1: got out_valid=%b in_ready=%b, want 0 %b", nm, out_valid, in_ready, exp_rdy);
      else passed++;
      step();
      total++;
      if ({out_valid, s, c_out, ovf, acc, in_ready} !== {1'b1, es, ec, eo, eacc, exp_rdy})
         $display("FAIL %s_result: got ov=%b s=%h c=%b ovf=%b acc=%h rdy=%b, want 1 %h %b %b %h %b",
                  nm, out_valid, s, c_out, ovf, acc, in_ready, es, ec, eo, eacc, exp_rdy);
      else passed++;
      $display("%s: op=%0d a=%h b=%h cin=%b -> s=%h c_out=%b ovf=%b acc=%h",
               nm, o, va, vb, ci, s, c_out, ovf, acc);
      step();
      total++;
      if ({out_valid, in_ready} !== 2'b01)
         $display("FAIL %s_drain: got out_valid=%b in_ready=%b, want 0 1", nm, out_valid, in_ready);
      else passed++;
   endtask

   task automatic test_add_sub();
      send_check(OP_ADD, 32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0, 32'h0, "add_carry_chain");
      send_check(OP_ADD, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 32'h0, "add_pos_ovf");
      send_check(OP_SUB, 32'h00000000, 32'h00000001, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h0, "sub_borrow");
      send_check(OP_ADD, 32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 32'h0, "add_cin_wrap");
      send_check(OP_SUB, 32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0, 32'h0, "sub_ignores_cin");
      send_check(OP_SUB, 32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 32'h0, "sub_neg_ovf");
   endtask

   task automatic test_acc();
      send_check(OP_CLR, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h0, 1'b0, 1'b0, 32'h0, "clr_first");
      send_check(OP_ACC, 32'h00000005, 32'h0000DEAD, 1'b1, 32'h5, 1'b0, 1'b0, 32'h5, "acc_5");
      send_check(OP_ACC, 32'h00000007, 32'h0000BEEF, 1'b0, 32'hC, 1'b0, 1'b0, 32'hC, "acc_7");
      send_check(OP_ADD, 32'h00000001, 32'h00000002, 1'b0, 32'h3, 1'b0, 1'b0, 32'hC, "add_keeps_acc");
      send_check(OP_ACC, 32'hFFFFFFF8, 32'h0, 1'b0, 32'h4, 1'b1, 1'b0, 32'h4, "acc_wrap");
      send_check(OP_CLR, 32'h12345678, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, "clr_again");
   endtask

   task automatic test_back_to_back();
      int          sent, recv;
      logic        held, fire_in;
      logic [31:0] held_s, exp_s;
      sent = 0; recv = 0; held = 1'b0; held_s = '0;
      for (int cyc = 0; cyc < 40 && recv < 8; cyc++) begin
         out_ready = !(cyc >= 3 && cyc <= 6);
         in_valid  = (sent < 8);
         op = OP_ADD; c_in = 1'b0;
         a = 32'hFFFFFFF0 + 32'(sent);
         b = 32'(sent) * 32'd3;
         #1;
         if (held) begin
            total++;
            if ({out_valid, s} !== {1'b1, held_s})
               $display("FAIL b2b_stall_hold cyc %0d: got ov=%b s=%h, want 1 %h", cyc, out_valid, s, held_s);
            else passed++;
         end
         held   = out_valid && !out_ready;
         held_s = s;
         if (out_valid && out_ready) begin
            exp_s = (32'hFFFFFFF0 + 32'(recv)) + 32'(recv) * 32'd3;
            total++;
            if (s !== exp_s)
               $display("FAIL b2b_result %0d: got s=%h, want %h", recv, s, exp_s);
            else passed++;
            $display("b2b %0d: s=%h c_out=%b", recv, s, c_out);
            recv++;
         end
         fire_in = in_valid && in_ready;
         step();
         if (fire_in) sent++;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      total++;
      if (recv !== 8 || sent !== 8)
         $display("FAIL b2b_count: got sent=%0d recv=%0d, want 8 8", sent, recv);
      else passed++;
      step(); step();
      total++;
      if (out_valid !== 1'b0)
         $display("FAIL b2b_no_dup: got out_valid=%b, want 0", out_valid);
      else passed++;
   endtask

   task automatic test_reset_midflight();
      send_check(OP_ACC, 32'h00000009, 32'h0, 1'b0, 32'h9, 1'b0, 1'b0, 32'h9, "acc_9");
      in_valid = 1'b1; op = OP_ADD; a = 32'h1; b = 32'h1; c_in = 1'b0;
      step();
      a = 32'h2;
      step();
      in_valid = 1'b0;
      total++;
      if (out_valid !== 1'b1)
         $display("FAIL rst_pre_inflight: got out_valid=%b, want 1", out_valid);
      else passed++;
      rst = 1'b1;
      #1;
      total++;
      if ({out_valid, s, acc} !== {1'b0, 32'h0, 32'h0})
         $display("FAIL rst_midflight: got ov=%b s=%h acc=%h, want 0 0 0", out_valid, s, acc);
      else passed++;
      step();
      rst = 1'b0;
      $display("reset pulsed with 2 ops in flight");
      for (int i = 0; i < 4; i++) begin
         step();
         total++;
         if (out_valid !== 1'b0)
            $display("FAIL rst_stale_%0d: got out_valid=%b, want 0", i, out_valid);
         else passed++;
      end
      send_check(OP_ADD, 32'h2, 32'h3, 1'b0, 32'h5, 1'b0, 1'b0, 32'h0, "add_after_rst");
   endtask

   task automatic test_sweep();
      logic [16:0] r16;
      logic [64:0] r64;
      logic        e_ovf16, e_ovf64;
      for (int i = 0; i < 30; i++) begin
         sw_op  = ($urandom_range(0, 1) == 1) ? OP_SUB : OP_ADD;
         sw_cin = 1'($urandom_range(0, 1));
         a16 = 16'($urandom); b16 = 16'($urandom);
         a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
         if (sw_op == OP_ADD) begin
            r16 = {1'b0, a16} + {1'b0, b16} + 17'(sw_cin);
            r64 = {1'b0, a64} + {1'b0, b64} + 65'(sw_cin);
            e_ovf16 = (a16[15] == b16[15]) && (r16[15] != a16[15]);
            e_ovf64 = (a64[63] == b64[63]) && (r64[63] != a64[63]);
         end else begin
            r16 = {1'b0, a16} + {1'b0, ~b16} + 17'd1;
            r64 = {1'b0, a64} + {1'b0, ~b64} + 65'd1;
            e_ovf16 = (a16[15] != b16[15]) && (r16[15] != a16[15]);
            e_ovf64 = (a64[63] != b64[63]) && (r64[63] != a64[63]);
         end
         sw_valid = 1'b1;
         step();
         sw_valid = 1'b0;
         step();
         total++;
         if ({ov16, c16, s16, ovf16} !== {1'b1, r16, e_ovf16})
            $display("FAIL sweep16_%0d: got ov=%b c=%b s=%h ovf=%b, want 1 %b %h %b",
                     i, ov16, c16, s16, ovf16, r16[16], r16[15:0], e_ovf16);
         else passed++;
         total++;
         if ({ov64, c64, s64, ovf64} !== {1'b1, r64, e_ovf64})
            $display("FAIL sweep64_%0d: got ov=%b c=%b s=%h ovf=%b, want 1 %b %h %b",
                     i, ov64, c64, s64, ovf64, r64[64], r64[63:0], e_ovf64);
         else passed++;
         $display("sweep %0d op=%0d: s16=%h c16=%b v16=%b s64=%h c64=%b v64=%b",
                  i, sw_op, s16, c16, ovf16, s64, c64, ovf64);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_add_sub();
      test_acc();
      test_back_to_back();
      test_reset_midflight();
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
